// File: rtl/filter_sweep_ctrl_pkg.sv
// package_settings: shared widths and the sweep FSM state type for the
// filter sweep controller slice.
//   SIZE_DELAY        width of delay values (test_delay, bounds, step)
//   SIZE_ADC_DATA     width of raw ADC samples
//   SIZE_FILTER_DATA  width of one signed filter output
//   SIZE_FILTER_SEL   width of the filter index
package package_settings;

  localparam int SIZE_DELAY       = 10;
  localparam int SIZE_ADC_DATA    = 14;
  localparam int SIZE_FILTER_DATA = 16;
  localparam int SIZE_FILTER_SEL  = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    REPORT
  } sweep_state_t;

endpackage

// File: rtl/filter_sweep_ctrl_peak_detector.sv
// peak_detector: signed running-maximum register.
//   clk     clock
//   reset   synchronous, active-low reset (peak -> 0)
//   clear   load peak with data (first sample of a window)
//   enable  fold data into peak with a signed max
//   data    signed sample
//   peak    signed running maximum
module peak_detector #(
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] data,
  output logic signed [DATA_W-1:0] peak
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      peak <= '0;
    end else if (clear) begin
      peak <= data;
    end else if (enable && (data > peak)) begin
      peak <= data;
    end
  end

endmodule

// File: rtl/filter_sweep_ctrl.sv
// filter_sweep_ctrl: steps a test delay from delay_first to delay_last,
// lets the filters settle after each change, captures the signed peak of
// one selected filter output, and hands each (delay, peak) result out on a
// valid/ready interface.
//   clk, reset                 clock; synchronous active-low reset
//   start, overlay_cfg         sweep request and overlay setting (latched)
//   delay_first/last/step      sweep bounds and increment (latched)
//   filter_sel, filter_data    filter index; all filter outputs, filter 0 in LSBs
//   test_overlay, test_rate,
//   test_delay                 drive to the unit under test
//   busy, done                 sweep in progress; one-cycle end pulse
//   res_valid/ready/delay/peak result handshake
// Optional build macro FILTER_SWEEP_ABORT_EN adds an abort input that ends
// the sweep from any non-idle state, with a done pulse.
module filter_sweep_ctrl
  import package_settings::*;
#(
  parameter int unsigned N_FILTERS     = 14,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned MEAS_CYCLES   = 256
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  overlay_cfg,
  input  logic [SIZE_DELAY-1:0]                 delay_first,
  input  logic [SIZE_DELAY-1:0]                 delay_last,
  input  logic [SIZE_DELAY-1:0]                 delay_step,
`ifdef FILTER_SWEEP_ABORT_EN
  input  logic                                  abort,
`endif
  input  logic [SIZE_FILTER_SEL-1:0]            filter_sel,
  input  logic [N_FILTERS*SIZE_FILTER_DATA-1:0] filter_data,
  output logic                                  test_overlay,
  output logic                                  test_rate,
  output logic [SIZE_DELAY-1:0]                 test_delay,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic [SIZE_DELAY-1:0]                 res_delay,
  output logic signed [SIZE_FILTER_DATA-1:0]    res_peak
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > MEAS_CYCLES) ? SETTLE_CYCLES : MEAS_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [SIZE_FILTER_SEL-1:0] SEL_MAX = SIZE_FILTER_SEL'(N_FILTERS - 1);

  sweep_state_t state, state_next;

  logic [CNT_W-1:0]                 cnt, cnt_next;
  logic                             overlay_q;
  logic [SIZE_FILTER_SEL-1:0]       sel_q;
  logic [SIZE_DELAY-1:0]            last_q;
  logic [SIZE_DELAY-1:0]            step_q;
  logic [SIZE_DELAY-1:0]            delay_q;
  logic                             done_q, done_next;
  logic                             load_cfg;
  logic                             advance;
  logic [SIZE_DELAY:0]              next_delay;
  logic                             sweep_end;
  logic signed [SIZE_FILTER_DATA-1:0] sel_data;
  logic signed [SIZE_FILTER_DATA-1:0] peak;
  logic                             peak_clear;
  logic                             peak_enable;

  // One extra bit catches wrap-around of the delay addition.
  assign next_delay = {1'b0, delay_q} + {1'b0, step_q};
  assign sweep_end  = next_delay[SIZE_DELAY] || (next_delay[SIZE_DELAY-1:0] > last_q);

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N_FILTERS; i++) begin
      if (sel_q == SIZE_FILTER_SEL'(i)) begin
        sel_data = filter_data[i*SIZE_FILTER_DATA +: SIZE_FILTER_DATA];
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_cfg   = 1'b0;
    advance    = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SETTLE;
          cnt_next   = '0;
          load_cfg   = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_next = MEASURE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      MEASURE: begin
        if (cnt == CNT_W'(MEAS_CYCLES - 1)) begin
          state_next = REPORT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      REPORT: begin
        if (res_ready) begin
          if (sweep_end) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = SETTLE;
            cnt_next   = '0;
            advance    = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
`ifdef FILTER_SWEEP_ABORT_EN
    // Abort overrides whatever the state decode chose, including a handshake.
    if (abort && (state != IDLE)) begin
      state_next = IDLE;
      cnt_next   = '0;
      advance    = 1'b0;
      done_next  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      overlay_q <= 1'b0;
      sel_q     <= '0;
      last_q    <= '0;
      step_q    <= '0;
      delay_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      done_q <= done_next;
      if (load_cfg) begin
        overlay_q <= overlay_cfg;
        sel_q     <= (filter_sel > SEL_MAX) ? SEL_MAX : filter_sel;
        last_q    <= delay_last;
        step_q    <= (delay_step == '0) ? SIZE_DELAY'(1) : delay_step;
        delay_q   <= delay_first;
      end else if (advance) begin
        delay_q <= next_delay[SIZE_DELAY-1:0];
      end
    end
  end

  // First MEASURE cycle loads the sample; the rest fold in the max.
  assign peak_enable = (state == MEASURE);
  assign peak_clear  = (state == MEASURE) && (cnt == '0);

  peak_detector #(
    .DATA_W(SIZE_FILTER_DATA)
  ) u_peak (
    .clk    (clk),
    .reset  (reset),
    .clear  (peak_clear),
    .enable (peak_enable),
    .data   (sel_data),
    .peak   (peak)
  );

  assign busy         = (state != IDLE);
  assign test_rate    = busy;
  assign test_overlay = busy & overlay_q;
  assign test_delay   = delay_q;
  assign done         = done_q;
  assign res_valid    = (state == REPORT);
  assign res_delay    = delay_q;
  assign res_peak     = peak;

endmodule

// File: tb/tb_filter_sweep_ctrl.sv
// Self-checking bench for filter_sweep_ctrl. Expected results come from a
// sweep model: the list of delays is derived from the bounds/step rules and
// each peak is the signed max of the selected filter over the measurement
// window, which opens SETTLE_CYCLES edges after each step begins.
module tb_filter_sweep_ctrl;
  import package_settings::*;

  localparam int N    = 14;
  localparam int S    = 64;
  localparam int M    = 256;
  localparam int W    = SIZE_FILTER_DATA;
  localparam int D    = SIZE_DELAY;
  localparam int DMAX = (1 << D) - 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 overlay_cfg;
  logic [D-1:0]         delay_first, delay_last, delay_step;
  logic                 abort;
  logic [3:0]           filter_sel;
  logic [N*W-1:0]       filter_data;
  logic                 test_overlay, test_rate;
  logic [D-1:0]         test_delay;
  logic                 busy, done;
  logic                 res_valid, res_ready;
  logic [D-1:0]         res_delay;
  logic signed [W-1:0]  res_peak;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  filter_sweep_ctrl #(
    .N_FILTERS     (N),
    .SETTLE_CYCLES (S),
    .MEAS_CYCLES   (M)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .overlay_cfg  (overlay_cfg),
    .delay_first  (delay_first),
    .delay_last   (delay_last),
    .delay_step   (delay_step),
`ifdef FILTER_SWEEP_ABORT_EN
    .abort        (abort),
`endif
    .filter_sel   (filter_sel),
    .filter_data  (filter_data),
    .test_overlay (test_overlay),
    .test_rate    (test_rate),
    .test_delay   (test_delay),
    .busy         (busy),
    .done         (done),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_delay    (res_delay),
    .res_peak     (res_peak)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fd(input int sel, input logic signed [W-1:0] v);
    for (int i = 0; i < N; i++) filter_data[i*W +: W] = W'($urandom);
    filter_data[sel*W +: W] = v;
  endtask

  task automatic run_sweep(input int first, input int last, input int step, input int sel,
                           input bit ovl, input bit ramp, input int stall, input bit rand_stall,
                           input bit poke);
    int q[$];
    int eff, d, eff_sel, n;
    logic signed [W-1:0] v, exp_peak;
    eff = (step == 0) ? 1 : step;
    d = first;
    q.push_back(d);
    while ((d + eff <= last) && (d + eff <= DMAX)) begin
      d = d + eff;
      q.push_back(d);
    end
    eff_sel = (sel >= N) ? N - 1 : sel;
    exp_peak = '0;

    delay_first = D'(first);
    delay_last  = D'(last);
    delay_step  = D'(step);
    filter_sel  = 4'(sel);
    overlay_cfg = ovl;
    start = 1'b1;
    tick();
    start = 1'b0;
    // Inputs change after latching; the sweep must not follow them.
    delay_first = D'($urandom); delay_last = D'($urandom); delay_step = D'($urandom);
    filter_sel = 4'($urandom); overlay_cfg = ~ovl;
    checks++;
    if (busy !== 1'b1 || test_rate !== 1'b1 || test_overlay !== ovl || test_delay !== D'(first)) begin
      errors++;
      $display("FAIL sweep_start: busy=%b rate=%b ovl=%b delay=%0d required busy=1 rate=1 ovl=%b delay=%0d",
               busy, test_rate, test_overlay, test_delay, ovl, first);
    end

    for (int j = 0; j < q.size(); j++) begin
      for (int k = 1; k <= S + M; k++) begin
        if (ramp) v = (k <= S) ? 16'sd1000 : W'(k - S - 1 - 5);
        else      v = W'($urandom);
        drive_fd(eff_sel, v);
        if (k == S + 1)                    exp_peak = v;
        else if (k > S + 1 && v > exp_peak) exp_peak = v;
        start = poke && ($urandom_range(0, 49) == 0);
        tick();
        if (k == S + M - 1) begin
          checks++;
          if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_valid: res_valid=%b required 0 (step %0d)", res_valid, j);
          end
        end
      end
      start = 1'b0;
      checks++;
      if (res_valid !== 1'b1 || res_delay !== D'(q[j]) || res_peak !== exp_peak ||
          test_delay !== D'(q[j]) || test_overlay !== ovl) begin
        errors++;
        $display("FAIL result: valid=%b delay=%0d peak=%0d tdelay=%0d ovl=%b required valid=1 delay=%0d peak=%0d ovl=%b",
                 res_valid, res_delay, res_peak, test_delay, test_overlay, q[j], exp_peak, ovl);
      end
      n = rand_stall ? $urandom_range(0, stall) : stall;
      res_ready = 1'b0;
      for (int c = 0; c < n; c++) begin
        drive_fd(eff_sel, W'($urandom));
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_delay !== D'(q[j]) || res_peak !== exp_peak || done !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold: valid=%b delay=%0d peak=%0d done=%b required valid=1 delay=%0d peak=%0d done=0",
                   res_valid, res_delay, res_peak, done, q[j], exp_peak);
        end
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      checks++;
      if (j == q.size() - 1) begin
        if (done !== 1'b1 || busy !== 1'b0 || test_rate !== 1'b0 || test_overlay !== 1'b0 || res_valid !== 1'b0) begin
          errors++;
          $display("FAIL sweep_end: done=%b busy=%b rate=%b ovl=%b valid=%b required done=1 others 0",
                   done, busy, test_rate, test_overlay, res_valid);
        end
      end else begin
        if (done !== 1'b0 || busy !== 1'b1 || res_valid !== 1'b0 || test_delay !== D'(q[j+1])) begin
          errors++;
          $display("FAIL step_advance: done=%b busy=%b valid=%b delay=%0d required done=0 busy=1 valid=0 delay=%0d",
                   done, busy, res_valid, test_delay, q[j+1]);
        end
      end
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_done: done=%b busy=%b valid=%b required all 0", done, busy, res_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; overlay_cfg = 1'b1; res_ready = 1'b1; abort = 1'b0;
    delay_first = '1; delay_last = '1; delay_step = '1; filter_sel = '1;
    filter_data = '1;
    repeat (3) tick();
    checks++;
    if ({test_overlay, test_rate, test_delay, busy, done, res_valid, res_delay, res_peak} !== '0) begin
      errors++;
      $display("FAIL reset_state: ovl=%b rate=%b delay=%0d busy=%b done=%b valid=%b rdelay=%0d peak=%0d required all 0",
               test_overlay, test_rate, test_delay, busy, done, res_valid, res_delay, res_peak);
    end
    reset = 1'b1;
    res_ready = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b valid=%b required 0 0", busy, res_valid);
    end
  endtask

  task automatic test_basic_sweep();
    run_sweep(10, 30, 10, 2, 1'b1, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_settle_exclusion();
    run_sweep(7, 7, 1, 5, 1'b0, 1'b1, 3, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_sweep(100, 101, 1, 0, 1'b1, 1'b0, 100, 1'b0, 1'b0);
  endtask

  task automatic test_step_bounds();
    run_sweep(5, 5, 0, 3, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    run_sweep(DMAX - 1, DMAX, 4, 4, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    run_sweep(DMAX - 3, DMAX, 3, 6, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_sweep(30, 10, 5, 1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_sweep(200, 240, 20, 9, 1'b1, 1'b0, 4, 1'b1, 1'b1);
  endtask

  task automatic test_filter_clamp();
    run_sweep(50, 50, 1, 15, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_sweep(60, 60, 1, 14, 1'b1, 1'b1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_measure();
    delay_first = D'(40); delay_last = D'(80); delay_step = D'(8);
    filter_sel = 4'd1; overlay_cfg = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < S + 40; k++) begin
      drive_fd(1, 16'sd300);
      tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if ({test_overlay, test_rate, test_delay, busy, done, res_valid, res_delay, res_peak} !== '0) begin
      errors++;
      $display("FAIL reset_mid_sweep: ovl=%b rate=%b delay=%0d busy=%b done=%b valid=%b rdelay=%0d peak=%0d required all 0",
               test_overlay, test_rate, test_delay, busy, done, res_valid, res_delay, res_peak);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL no_done_after_reset: done=%b busy=%b required 0 0", done, busy);
      end
    end
  endtask

  task automatic test_random_sweeps();
    int first, step, eff, last;
    for (int r = 0; r < 5; r++) begin
      first = $urandom_range(0, DMAX);
      step  = $urandom_range(0, 200);
      eff   = (step == 0) ? 1 : step;
      if ($urandom_range(0, 3) == 0) last = $urandom_range(0, DMAX);
      else begin
        last = first + $urandom_range(0, 2 * eff);
        if (last > DMAX) last = DMAX;
      end
      run_sweep(first, last, step, $urandom_range(0, 15), 1'($urandom), 1'b0, 6, 1'b1, 1'b1);
    end
  endtask

`ifdef FILTER_SWEEP_ABORT_EN
  task automatic test_abort();
    delay_first = D'(1); delay_last = D'(500); delay_step = D'(1);
    filter_sel = 4'd0; overlay_cfg = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || test_rate !== 1'b0) begin
      errors++;
      $display("FAIL abort_settle: done=%b busy=%b valid=%b rate=%b required 1 0 0 0",
               done, busy, res_valid, test_rate);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_after: done=%b busy=%b required 0 0", done, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_sweep();
    test_settle_exclusion();
    test_backpressure();
    test_step_bounds();
    test_start_ignored();
    test_filter_clamp();
    test_reset_mid_measure();
    test_random_sweeps();
`ifdef FILTER_SWEEP_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
